// File: rtl/energy_sample_scheduler_if.sv
// Bus between the energy sample scheduler and its sources/collector.
// master: scheduler side (drives grant, sample and status).
// slave : source mux / data_collector side (drives requests and collector data).
interface energy_sample_scheduler_if #(
   parameter int N_CH = 4
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0] req;
   logic [N_CH-1:0] grant;
   logic [CW-1:0]   sel;
   logic [7:0]      coll_data;
   logic [7:0]      smp_data;
   logic [CW-1:0]   smp_ch;
   logic            smp_valid;
   logic            busy;
   logic [N_CH-1:0] trip;

   modport master (
      input  req, coll_data,
      output grant, sel, smp_data, smp_ch, smp_valid, busy, trip
   );

   modport slave (
      output req, coll_data,
      input  grant, sel, smp_data, smp_ch, smp_valid, busy, trip
   );
endinterface

// File: rtl/energy_sample_scheduler.sv
// Energy sample scheduler: time-shares one 8-bit data_collector path between
// N_CH sources. Round-robin arbitration, fixed settle window, tagged capture.
// Optional feature macro: OVERVOLT_TRIP_EN (sticky per-channel over-voltage
// trip; tripped channels drop out of arbitration). Undefined: trip tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; arbitrate eligible requests every cycle
// S_GRANT | one source granted; cnt_q counts the settle window down
// S_GAP   | grant released; idle guard time before next arbitration
module energy_sample_scheduler #(
   parameter int         N_CH       = 4,
   parameter int         SAMPLE_CYC = 8,
   parameter int         GAP_CYC    = 2,
   parameter logic [7:0] TRIP_LEVEL = 8'hF0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   energy_sample_scheduler_if.master   bus
);
   localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_MAX  = (SAMPLE_CYC - 1 > GAP_CYC) ? SAMPLE_CYC - 1 : GAP_CYC;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CW-1:0]   rr_ptr_q;
   logic [N_CH-1:0] grant_q;
   logic [CW-1:0]   sel_q;
   logic [7:0]      smp_data_q;
   logic [CW-1:0]   smp_ch_q;
   logic            smp_valid_q;
   logic            busy_q;

   logic [N_CH-1:0] elig;
   logic            found_d;
   logic [CW-1:0]   winner_d;
   logic [CW:0]     cand;

`ifdef OVERVOLT_TRIP_EN
   logic [N_CH-1:0] trip_q;
   assign elig     = bus.req & ~trip_q;
   assign bus.trip = trip_q;
`else
   assign elig     = bus.req;
   assign bus.trip = '0;
`endif

   // Round-robin search: first eligible channel strictly after rr_ptr_q, wrapping.
   always_comb begin
      found_d  = 1'b0;
      winner_d = '0;
      cand     = '0;
      for (int i = 1; i <= N_CH; i++) begin
         cand = {1'b0, rr_ptr_q} + (CW+1)'(i);
         if (cand >= (CW+1)'(N_CH)) begin
            cand = cand - (CW+1)'(N_CH);
         end
         if (!found_d && elig[cand[CW-1:0]]) begin
            found_d  = 1'b1;
            winner_d = cand[CW-1:0];
         end
      end
   end

   // Sequencer FSM with all outputs registered; a window ends either by capture
   // (cnt_q reaches 0) or by abort (granted request withdrawn before that).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rr_ptr_q    <= CW'(N_CH - 1);
         grant_q     <= '0;
         sel_q       <= '0;
         smp_data_q  <= '0;
         smp_ch_q    <= '0;
         smp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef OVERVOLT_TRIP_EN
         trip_q      <= '0;
`endif
      end else begin
         smp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  state_q  <= S_GRANT;
                  grant_q  <= N_CH'(1) << winner_d;
                  sel_q    <= winner_d;
                  busy_q   <= 1'b1;
                  cnt_q    <= CNT_W'(SAMPLE_CYC - 1);
                  rr_ptr_q <= winner_d;
               end
            end
            S_GRANT: begin
               if (cnt_q == '0 || !bus.req[sel_q]) begin
                  if (cnt_q == '0) begin
                     smp_data_q  <= bus.coll_data;
                     smp_ch_q    <= sel_q;
                     smp_valid_q <= 1'b1;
`ifdef OVERVOLT_TRIP_EN
                     if (bus.coll_data >= TRIP_LEVEL) begin
                        trip_q[sel_q] <= 1'b1;
                     end
`endif
                  end
                  grant_q <= '0;
                  sel_q   <= '0;
                  if (GAP_CYC == 0) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_GAP;
                     cnt_q   <= CNT_W'(GAP_LOAD);
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_GAP: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
               sel_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.sel       = sel_q;
   assign bus.smp_data  = smp_data_q;
   assign bus.smp_ch    = smp_ch_q;
   assign bus.smp_valid = smp_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_energy_sample_scheduler.sv
// Testbench for energy_sample_scheduler. A timestamp-based reference model
// (window start cycle, earliest arbitration cycle) predicts every output each
// cycle; directed scenarios add constant expectations. Trip scenario only
// when OVERVOLT_TRIP_EN is defined.
module tb_energy_sample_scheduler;
   localparam int N  = 4;
   localparam int S  = 8;
   localparam int G  = 2;
   localparam logic [7:0] TL = 8'hF0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   energy_sample_scheduler_if #(.N_CH(N)) bus();

   energy_sample_scheduler #(
      .N_CH(N), .SAMPLE_CYC(S), .GAP_CYC(G), .TRIP_LEVEL(TL)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int passes = 0;
   int total  = 0;

   // reference model state
   int         n;          // index of current cycle since reset
   bit         act;        // a grant window is open
   int         g_start, g_ch, idle_from, last;
   logic [7:0] m_data;
   int         m_ch;
   bit         m_valid;
   logic [N-1:0] m_trip;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      n = 0; act = 0; idle_from = 0; last = N - 1;
      m_data = 8'h00; m_ch = 0; m_valid = 0; m_trip = '0;
   endtask

   // Advance the model over one clock edge using the inputs present at it.
   task automatic model_edge();
      int prev;
      logic [N-1:0] el;
      if (rst) begin
         model_reset();
         return;
      end
      prev = n;
      n = n + 1;
      m_valid = 0;
      if (act) begin
         if (prev - g_start == S - 1) begin
            m_valid = 1; m_data = bus.coll_data; m_ch = g_ch;
`ifdef OVERVOLT_TRIP_EN
            if (bus.coll_data >= TL) m_trip[g_ch] = 1'b1;
`endif
            act = 0; idle_from = n + G;
         end else if (!bus.req[g_ch]) begin
            act = 0; idle_from = n + G;
         end
      end else if (prev >= idle_from) begin
         el = bus.req & ~m_trip;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (!act && el[c]) begin
               act = 1; g_start = n; g_ch = c; last = c;
            end
         end
      end
   endtask

   task automatic step();
      logic [N-1:0] eg;
      @(posedge clk);
      #1;
      model_edge();
      eg = act ? (N'(1) << g_ch) : '0;
      chk("grant",     bus.grant,     eg);
      chk("sel",       bus.sel,       act ? g_ch : 0);
      chk("busy",      bus.busy,      (act || n < idle_from) ? 1 : 0);
      chk("smp_valid", bus.smp_valid, m_valid);
      chk("smp_data",  bus.smp_data,  m_data);
      chk("smp_ch",    bus.smp_ch,    m_ch);
      chk("trip",      bus.trip,      m_trip);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) step();
      rst = 1'b0;
   endtask

   initial begin
      int gcnt, vcnt, first_g, v_at, seen;
      logic [7:0] v_data;
      int v_ch;
      int order[$];
      logic [N-1:0] prev_g;

      model_reset();
      rst = 1'b1;
      bus.req = 4'hF;
      bus.coll_data = 8'h00;

      // reset with all requests high
      do_reset(3);
      chk("rst_grant", bus.grant, 0);
      chk("rst_busy",  bus.busy, 0);

      // single request on ch2
      bus.req = 4'b0100; bus.coll_data = 8'h5A;
      gcnt = 0; vcnt = 0; first_g = -1; v_at = -1; v_data = 8'h00; v_ch = -1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 12) bus.req = 4'b0000;
         step();
         if (bus.grant == 4'b0100) begin
            gcnt++;
            if (first_g < 0) first_g = i;
         end
         if (bus.smp_valid) begin
            vcnt++; v_at = i; v_data = bus.smp_data; v_ch = int'(bus.smp_ch);
         end
      end
      chk("single_grant_len", gcnt, S);
      chk("single_valid_cnt", vcnt, 1);
      chk("single_smp_data",  v_data, 8'h5A);
      chk("single_smp_ch",    v_ch, 2);
      chk("single_latency",   v_at - first_g, S);

      // fairness with all requests held
      do_reset(2);
      bus.req = 4'hF; bus.coll_data = 8'h33;
      prev_g = '0;
      for (int i = 0; i < 56; i++) begin
         step();
         if (bus.grant != '0 && prev_g == '0) order.push_back(oh_idx(bus.grant));
         prev_g = bus.grant;
      end
      chk("rr_count", order.size() >= 5 ? 1 : 0, 1);
      for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], i % N);

      // abort: ch1 request withdrawn in 4th grant cycle
      do_reset(2);
      bus.req = 4'b0010;
      seen = 0;
      for (int i = 0; i < 5 && !seen; i++) begin
         step();
         if (bus.grant == 4'b0010) seen = 1;
      end
      chk("abort_wait_grant", seen, 1);
      for (int i = 0; i < 3; i++) step();
      chk("abort_grant_c4", bus.grant, 4'b0010);
      bus.req = 4'b0000;
      vcnt = 0;
      step(); vcnt += bus.smp_valid;
      chk("abort_gap1_grant", bus.grant, 0);
      chk("abort_gap1_busy",  bus.busy, 1);
      step(); vcnt += bus.smp_valid;
      chk("abort_gap2_busy",  bus.busy, 1);
      step(); vcnt += bus.smp_valid;
      chk("abort_idle_busy",  bus.busy, 0);
      chk("abort_no_valid",   vcnt, 0);

      // reset pulsed in grant cycle 5 of ch1
      do_reset(2);
      bus.req = 4'hF;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (bus.grant == 4'b0010) seen = 1;
      end
      chk("midrst_wait_ch1", seen, 1);
      for (int i = 0; i < 4; i++) step();
      chk("midrst_grant_c5", bus.grant, 4'b0010);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_grant", bus.grant, 0);
      chk("midrst_busy",  bus.busy, 0);
      chk("midrst_valid", bus.smp_valid, 0);
      chk("midrst_sel",   bus.sel, 0);
      step();
      chk("midrst_next_ch0", bus.grant, 4'b0001);

`ifdef OVERVOLT_TRIP_EN
      // over-voltage on ch3 locks it out
      do_reset(2);
      bus.req = 4'b1000; bus.coll_data = 8'hF5;
      for (int i = 0; i < 12; i++) step();
      chk("trip_ch3", bus.trip, 4'b1000);
      bus.req = 4'hF; bus.coll_data = 8'h10;
      gcnt = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.grant[3]) gcnt++;
      end
      chk("trip_ch3_locked", gcnt, 0);
`endif

      // randomized traffic against the model
      do_reset(2);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(7, 0) == 0) bus.req = N'($urandom());
         bus.coll_data = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 240))
                                                     : 8'($urandom());
         rst = ($urandom_range(249, 0) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
